hms_timer_core: RTL and testbench
=================================

// Module: hms_timer_core
// PURPOSE
//  Parametrised HH-MM-SS timer with built-in 8-digit multiplexed 7-segment driver (Nexys 4 DDR).
//  Single clock domain; all dividers are clock-enable ticks, never derived clocks.
//  Adds over the previous timer: up/down mode, run/pause, BCD preset load with validation,
//  a countdown-done flag and a wrap pulse. Sits between board buttons/switches and the display pins.
// PARAMETERS
//  TICK_DIV0  100_000_000  clk cycles per time step, speed_up=0 (1 s at 100 MHz)
//  TICK_DIV1  10_000_000   cycles per step, speed_up=1
//  TICK_DIV2  1_000_000    cycles per step, speed_up=2
//  TICK_DIV3  10_000       cycles per step, speed_up=3
//  SCAN_DIV   100_000      clk cycles each digit stays lit (all DIVs >= 2)
//  HH_MAX     23           highest hour value, 1..99; up-count wraps after HH_MAX:59:59
// PORTS
//  clk       in   1   system clock, E3 oscillator
//  reset     in   1   asynchronous, active-low reset
//  run       in   1   1 = count on ticks, 0 = hold (display keeps scanning)
//  down      in   1   0 = count up, 1 = count down
//  speed_up  in   2   selects TICK_DIV0..3
//  load      in   1   1-cycle pulse: preset time from load_bcd
//  load_bcd  in   24  {H1,H0,M1,M0,S1,S0}, 4-bit BCD each
//  clear     in   1   1-cycle pulse: time := 00:00:00
//  time_bcd  out  24  current time, same packing as load_bcd
//  done      out  1   sticky: countdown reached 00:00:00
//  wrap      out  1   1-cycle pulse on up-count HH_MAX:59:59 -> 00:00:00
//  load_err  out  1   1-cycle pulse: load rejected
//  out_num   out  7   segments {g,f,e,d,c,b,a}, active-low
//  out_dis   out  8   digit enables, active-low one-hot; bit 0 = leftmost digit
// BEHAVIOUR
//  Reset (async assert, sync release): time 00:00:00, done=0, wrap=0, load_err=0, tick and scan
//   counters 0, digit index 0, out_dis=8'b1111_1110, out_num=7'b1000000 ('0').
//  Tick gen: counter 0..TICK_DIVn-1; tick = 1-cycle pulse when count==DIV-1, then count -> 0.
//   Any change of speed_up restarts the counter at 0 with no tick that cycle.
//   Counter width = $clog2 of the largest TICK_DIV. Counter runs only while run=1.
//  Priority per cycle: clear > load > tick.
//  clear: time := 0, done := 0, tick counter := 0.
//  load: accepted iff every digit <=9, M1<=5, S1<=5, H1*10+H0<=HH_MAX;
//   accepted -> time := load_bcd next cycle, done := 0, tick counter := 0;
//   rejected -> time unchanged, load_err=1 for one cycle.
//  Tick with run=1, down=0: BCD increment with carry S0->S1(5)->M0->M1(5)->hours;
//   at HH_MAX:59:59 -> 00:00:00 and wrap=1 the same cycle the time updates. done unaffected.
//  Tick with run=1, down=1, done=0: BCD decrement with borrow (S0 0->9 borrows S1, S1 0->5, ...);
//   on reaching 00:00:00 set done in the same cycle. At 00:00:00 with done=1: hold, no wrap.
//   Entering down mode already at 00:00:00 with done=0: first tick sets done, time holds.
//  Hours are two BCD digits; increment/decrement in BCD (09->10, 10->09), never binary.
//  done cleared only by reset, clear or accepted load; it stays set if down is deasserted.
//  Display: scan counter 0..SCAN_DIV-1, digit index advances 0..7 then wraps to 0, independent
//   of run. Digit map 0..7 = H1,H0,'-',M1,M0,'-',S1,S0; '-' lights segment g only (7'b0111111).
//   out_num/out_dis registered from the same index (no ghosting between digits);
//   digits 0-9 use standard gfedcba active-low codes.
//  time_bcd, done, wrap, load_err are registered; no combinational input->output path.
// TESTING (TICK_DIV0..3=8,6,4,2; SCAN_DIV=2; HH_MAX=23)
//  Reset mid-count at 12:34:56 -> time_bcd=0, out_dis=FE, out_num=40, done=0, all the same cycle.
//  up, speed 3, load 23:59:58 -> 23:59:59 then 00:00:00 two ticks later with wrap=1 for exactly 1 cycle.
//  down, load 00:01:00 -> 00:00:59 after first tick; at 00:00:00 done=1; 5 more ticks, time holds.
//  load 24:00:00, 00:60:00 and 00:0A:00 -> each gives load_err pulse, time unchanged; clear+load same cycle -> 00:00:00.
//  run=0 for 40 cycles -> time frozen, out_dis keeps cycling FE,FD,...,7F every 2 cycles; '-' on digits 2 and 5.
//  speed_up 0->3 at tick count 5 -> next tick exactly 2 cycles after change; load on a tick cycle wins.

Source files
------------

// File: rtl/hms_timer_core_if.sv
// hms_timer_core_if
//  Control/status bundle for the HH-MM-SS timer core.
//  master: board-side controller (buttons/switches in, time and display out).
//  slave : the timer core itself.
//  Signals:
//   run, down, speed_up[1:0], load, load_bcd[23:0], clear   -> core
//   time_bcd[23:0], done, wrap, load_err, out_num[6:0], out_dis[7:0] <- core
interface hms_timer_core_if;
  logic        run;
  logic        down;
  logic [1:0]  speed_up;
  logic        load;
  logic [23:0] load_bcd;
  logic        clear;
  logic [23:0] time_bcd;
  logic        done;
  logic        wrap;
  logic        load_err;
  logic [6:0]  out_num;
  logic [7:0]  out_dis;

  modport master (
    output run, down, speed_up, load, load_bcd, clear,
    input  time_bcd, done, wrap, load_err, out_num, out_dis
  );

  modport slave (
    input  run, down, speed_up, load, load_bcd, clear,
    output time_bcd, done, wrap, load_err, out_num, out_dis
  );
endinterface

// File: rtl/hms_timer_core.sv
// hms_timer_core
//  HH-MM-SS BCD timer with up/down count, run/pause, validated preset load,
//  sticky countdown-done flag, wrap pulse and an 8-digit multiplexed
//  7-segment driver. Single clock; dividers are clock-enable ticks.
//  Ports:
//   clk    : system clock
//   reset  : asynchronous active-low reset (release synchronised internally)
//   bus    : hms_timer_core_if.slave
//            in : run, down, speed_up, load, load_bcd, clear
//            out: time_bcd, done, wrap, load_err (registered)
//                 out_num (gfedcba, active-low), out_dis (active-low, bit0 = leftmost)
module hms_timer_core #(
  parameter int unsigned TICK_DIV0 = 100_000_000,
  parameter int unsigned TICK_DIV1 = 10_000_000,
  parameter int unsigned TICK_DIV2 = 1_000_000,
  parameter int unsigned TICK_DIV3 = 10_000,
  parameter int unsigned SCAN_DIV  = 100_000,
  parameter int unsigned HH_MAX    = 23
) (
  input  logic              clk,
  input  logic              reset,
  hms_timer_core_if.slave   bus
);

  localparam int unsigned MAX01   = (TICK_DIV0 > TICK_DIV1) ? TICK_DIV0 : TICK_DIV1;
  localparam int unsigned MAX23   = (TICK_DIV2 > TICK_DIV3) ? TICK_DIV2 : TICK_DIV3;
  localparam int unsigned MAX_DIV = (MAX01 > MAX23) ? MAX01 : MAX23;
  localparam int unsigned TW      = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;
  localparam int unsigned SW      = $clog2(SCAN_DIV);

  localparam logic [3:0]  HH1     = 4'(HH_MAX / 10);
  localparam logic [3:0]  HH0     = 4'(HH_MAX % 10);
  localparam logic [23:0] T_MAX   = {HH1, HH0, 4'd5, 4'd9, 4'd5, 4'd9};
  localparam logic [6:0]  SEG_DASH = 7'b0111111;

  // BCD increment; caller handles the HH_MAX:59:59 rollover flag.
  function automatic logic [23:0] bcd_inc(input logic [23:0] t);
    logic [3:0] h1, h0, m1, m0, s1, s0;
    {h1, h0, m1, m0, s1, s0} = t;
    if (s0 != 4'd9) s0 = s0 + 4'd1;
    else begin
      s0 = '0;
      if (s1 != 4'd5) s1 = s1 + 4'd1;
      else begin
        s1 = '0;
        if (m0 != 4'd9) m0 = m0 + 4'd1;
        else begin
          m0 = '0;
          if (m1 != 4'd5) m1 = m1 + 4'd1;
          else begin
            m1 = '0;
            if (h1 == HH1 && h0 == HH0) begin
              h1 = '0;
              h0 = '0;
            end else if (h0 != 4'd9) h0 = h0 + 4'd1;
            else begin
              h0 = '0;
              h1 = h1 + 4'd1;
            end
          end
        end
      end
    end
    return {h1, h0, m1, m0, s1, s0};
  endfunction

  // BCD decrement; never called on 00:00:00.
  function automatic logic [23:0] bcd_dec(input logic [23:0] t);
    logic [3:0] h1, h0, m1, m0, s1, s0;
    {h1, h0, m1, m0, s1, s0} = t;
    if (s0 != 4'd0) s0 = s0 - 4'd1;
    else begin
      s0 = 4'd9;
      if (s1 != 4'd0) s1 = s1 - 4'd1;
      else begin
        s1 = 4'd5;
        if (m0 != 4'd0) m0 = m0 - 4'd1;
        else begin
          m0 = 4'd9;
          if (m1 != 4'd0) m1 = m1 - 4'd1;
          else begin
            m1 = 4'd5;
            if (h0 != 4'd0) h0 = h0 - 4'd1;
            else begin
              h0 = 4'd9;
              h1 = h1 - 4'd1;
            end
          end
        end
      end
    end
    return {h1, h0, m1, m0, s1, s0};
  endfunction

  function automatic logic load_valid(input logic [23:0] v);
    logic [3:0] h1, h0, m1, m0, s1, s0;
    logic [7:0] hours;
    {h1, h0, m1, m0, s1, s0} = v;
    hours = ({4'b0, h1} * 8'd10) + {4'b0, h0};
    return (h1 <= 4'd9) && (h0 <= 4'd9) && (m1 <= 4'd5) && (m0 <= 4'd9) &&
           (s1 <= 4'd5) && (s0 <= 4'd9) && (hours <= 8'(HH_MAX));
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Reset synchroniser: assertion is immediate, release aligned to clk.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_n;

  always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync_q <= '0;
    else        rst_sync_q <= rst_sync_d;
  end

  assign rst_n = rst_sync_q[1];

  logic [TW-1:0] tick_cnt_q, tick_cnt_d, div_m1;
  logic [1:0]    speed_prev_q, speed_prev_d;
  logic [23:0]   time_q, time_d;
  logic          done_q, done_d;
  logic          wrap_q, wrap_d;
  logic          load_err_q, load_err_d;
  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [2:0]    dig_idx_q, dig_idx_d;
  logic [6:0]    out_num_q, out_num_d;
  logic [7:0]    out_dis_q, out_dis_d;
  logic          tick;

  always_comb begin
    case (bus.speed_up)
      2'd0:    div_m1 = TW'(TICK_DIV0 - 1);
      2'd1:    div_m1 = TW'(TICK_DIV1 - 1);
      2'd2:    div_m1 = TW'(TICK_DIV2 - 1);
      default: div_m1 = TW'(TICK_DIV3 - 1);
    endcase
  end

  always_comb begin
    tick_cnt_d   = tick_cnt_q;
    speed_prev_d = bus.speed_up;
    time_d       = time_q;
    done_d       = done_q;
    wrap_d       = 1'b0;
    load_err_d   = 1'b0;
    tick         = 1'b0;

    // A speed change restarts the step period and swallows any tick that cycle.
    if (bus.speed_up != speed_prev_q) begin
      tick_cnt_d = '0;
    end else if (bus.run) begin
      if (tick_cnt_q == div_m1) begin
        tick_cnt_d = '0;
        tick       = 1'b1;
      end else begin
        tick_cnt_d = tick_cnt_q + TW'(1);
      end
    end

    if (bus.clear) begin
      time_d     = '0;
      done_d     = 1'b0;
      tick_cnt_d = '0;
    end else if (bus.load) begin
      // A rejected load still consumes the cycle's tick so time stays unchanged.
      if (load_valid(bus.load_bcd)) begin
        time_d     = bus.load_bcd;
        done_d     = 1'b0;
        tick_cnt_d = '0;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (tick) begin
      if (!bus.down) begin
        time_d = bcd_inc(time_q);
        wrap_d = (time_q == T_MAX);
      end else if (!done_q) begin
        if (time_q == '0) begin
          done_d = 1'b1;
        end else begin
          time_d = bcd_dec(time_q);
          done_d = (time_d == '0);
        end
      end
    end
  end

  always_comb begin
    scan_cnt_d = scan_cnt_q + SW'(1);
    dig_idx_d  = dig_idx_q;
    if (scan_cnt_q == SW'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      dig_idx_d  = dig_idx_q + 3'd1;
    end

    // Segments and enable both come from the next index/time so they change together.
    case (dig_idx_d)
      3'd0:    out_num_d = seg7(time_d[23:20]);
      3'd1:    out_num_d = seg7(time_d[19:16]);
      3'd3:    out_num_d = seg7(time_d[15:12]);
      3'd4:    out_num_d = seg7(time_d[11:8]);
      3'd6:    out_num_d = seg7(time_d[7:4]);
      3'd7:    out_num_d = seg7(time_d[3:0]);
      default: out_num_d = SEG_DASH;
    endcase
    out_dis_d = ~(8'd1 << dig_idx_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q   <= '0;
      speed_prev_q <= '0;
      time_q       <= '0;
      done_q       <= 1'b0;
      wrap_q       <= 1'b0;
      load_err_q   <= 1'b0;
      scan_cnt_q   <= '0;
      dig_idx_q    <= '0;
      out_num_q    <= 7'b1000000;
      out_dis_q    <= 8'b1111_1110;
    end else begin
      tick_cnt_q   <= tick_cnt_d;
      speed_prev_q <= speed_prev_d;
      time_q       <= time_d;
      done_q       <= done_d;
      wrap_q       <= wrap_d;
      load_err_q   <= load_err_d;
      scan_cnt_q   <= scan_cnt_d;
      dig_idx_q    <= dig_idx_d;
      out_num_q    <= out_num_d;
      out_dis_q    <= out_dis_d;
    end
  end

  assign bus.time_bcd = time_q;
  assign bus.done     = done_q;
  assign bus.wrap     = wrap_q;
  assign bus.load_err = load_err_q;
  assign bus.out_num  = out_num_q;
  assign bus.out_dis  = out_dis_q;

endmodule

// File: tb/tb_hms_timer_core.sv
module tb_hms_timer_core;
  logic clk;
  logic reset;

  hms_timer_core_if bus ();

  hms_timer_core #(
    .TICK_DIV0(8),
    .TICK_DIV1(6),
    .TICK_DIV2(4),
    .TICK_DIV3(2),
    .SCAN_DIV (2),
    .HH_MAX   (23)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [23:0] t;
    logic        d;
    logic        w;
    logic        e;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [26:0] prev   = '0;
  logic [6:0]  seg_exp[8] = '{7'h79, 7'h24, 7'h3F, 7'h30, 7'h19, 7'h3F, 7'h12, 7'h02};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Monitor: any change in the registered status outputs is one DUT event.
  always @(negedge clk) begin : mon
    logic [26:0] snap;
    exp_t        e;
    snap = {bus.time_bcd, bus.done, bus.wrap, bus.load_err};
    if (snap !== prev) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL event_unexpected: got time=%h done=%b wrap=%b err=%b, required no change",
                 bus.time_bcd, bus.done, bus.wrap, bus.load_err);
      end else begin
        e = exp_q.pop_front();
        if (snap !== {e.t, e.d, e.w, e.e}) begin
          errors++;
          $display("FAIL event: got time=%h done=%b wrap=%b err=%b, required time=%h done=%b wrap=%b err=%b",
                   bus.time_bcd, bus.done, bus.wrap, bus.load_err, e.t, e.d, e.w, e.e);
        end
      end
      prev = snap;
    end
  end

  task automatic push(input logic [23:0] t, input logic d, input logic w, input logic e);
    exp_t x;
    x.t = t; x.d = d; x.w = w; x.e = e;
    exp_q.push_back(x);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic pulse_load(input logic [23:0] v);
    bus.load_bcd = v;
    bus.load     = 1'b1;
    step();
    bus.load     = 1'b0;
  endtask

  initial begin
    logic [7:0] p;
    logic [7:0] ed;
    int         idx0;
    bit         found;

    reset        = 1'b1;
    bus.run      = 1'b0;
    bus.down     = 1'b0;
    bus.speed_up = 2'd3;
    bus.load     = 1'b0;
    bus.load_bcd = '0;
    bus.clear    = 1'b0;
    #2 reset = 1'b0;
    repeat (3) step();

    chk("reset_time",  32'(bus.time_bcd), 32'h000000);
    chk("reset_dis",   32'(bus.out_dis),  32'hFE);
    chk("reset_num",   32'(bus.out_num),  32'h40);
    chk("reset_done",  32'(bus.done),     32'h0);
    chk("reset_wrap",  32'(bus.wrap),     32'h0);
    chk("reset_err",   32'(bus.load_err), 32'h0);

    reset = 1'b1;
    repeat (4) step();

    // Reset asserted mid-count at 12:34:56
    push(24'h123456, 0, 0, 0);
    pulse_load(24'h123456);
    bus.run = 1'b1;
    step();
    push(24'h000000, 0, 0, 0);
    reset = 1'b0;
    #1;
    chk("midrst_time", 32'(bus.time_bcd), 32'h000000);
    chk("midrst_dis",  32'(bus.out_dis),  32'hFE);
    chk("midrst_num",  32'(bus.out_num),  32'h40);
    chk("midrst_done", 32'(bus.done),     32'h0);
    bus.run = 1'b0;
    step();
    reset = 1'b1;
    repeat (4) step();

    // Up-count wrap from 23:59:58
    push(24'h235958, 0, 0, 0);
    pulse_load(24'h235958);
    push(24'h235959, 0, 0, 0);
    push(24'h000000, 0, 1, 0);
    push(24'h000000, 0, 0, 0);
    bus.run = 1'b1;
    repeat (5) step();
    bus.run = 1'b0;
    step();
    chk("wrap_end_time", 32'(bus.time_bcd), 32'h000000);
    chk("wrap_end_wrap", 32'(bus.wrap),     32'h0);

    // Countdown from 00:01:00 to done, then 5 held ticks
    bus.down = 1'b1;
    push(24'h000100, 0, 0, 0);
    pulse_load(24'h000100);
    for (int s = 59; s >= 1; s--) push({16'h0000, 4'(s / 10), 4'(s % 10)}, 0, 0, 0);
    push(24'h000000, 1, 0, 0);
    bus.run = 1'b1;
    repeat (130) step();
    bus.run = 1'b0;
    step();
    chk("down_done", 32'(bus.done),     32'h1);
    chk("down_time", 32'(bus.time_bcd), 32'h000000);

    // Rejected loads
    push(24'h000000, 1, 0, 1); push(24'h000000, 1, 0, 0);
    pulse_load(24'h240000); step();
    push(24'h000000, 1, 0, 1); push(24'h000000, 1, 0, 0);
    pulse_load(24'h006000); step();
    push(24'h000000, 1, 0, 1); push(24'h000000, 1, 0, 0);
    pulse_load(24'h000A00); step();
    chk("bad_load_time", 32'(bus.time_bcd), 32'h000000);

    // clear beats load
    push(24'h111111, 0, 0, 0);
    pulse_load(24'h111111);
    step();
    push(24'h000000, 0, 0, 0);
    bus.clear    = 1'b1;
    bus.load     = 1'b1;
    bus.load_bcd = 24'h222222;
    step();
    bus.clear = 1'b0;
    bus.load  = 1'b0;
    step();
    chk("clear_load_time", 32'(bus.time_bcd), 32'h000000);
    bus.down = 1'b0;

    // Paused: display keeps scanning 12-34-56
    push(24'h123456, 0, 0, 0);
    pulse_load(24'h123456);
    p     = bus.out_dis;
    found = 1'b0;
    for (int i = 0; i < 4 && !found; i++) begin
      step();
      if (bus.out_dis != p) found = 1'b1;
    end
    chk("scan_moves", 32'(found), 32'h1);
    idx0 = -1;
    for (int i = 0; i < 8; i++) begin
      ed = ~(8'd1 << i);
      if (bus.out_dis == ed) idx0 = i;
    end
    chk("scan_onehot", 32'(idx0 >= 0), 32'h1);
    if (idx0 < 0) idx0 = 0;
    for (int k = 0; k < 32; k++) begin
      if (k > 0) step();
      ed = ~(8'd1 << ((idx0 + k / 2) % 8));
      chk("scan_dis", 32'(bus.out_dis), 32'(ed));
      chk("scan_num", 32'(bus.out_num), 32'(seg_exp[(idx0 + k / 2) % 8]));
    end
    repeat (10) step();
    chk("pause_time", 32'(bus.time_bcd), 32'h123456);

    // Speed change restarts the period; load beats tick
    bus.speed_up = 2'd0;
    step();
    push(24'h010000, 0, 0, 0);
    pulse_load(24'h010000);
    push(24'h010001, 0, 0, 0);
    bus.run = 1'b1;
    repeat (5) step();
    bus.speed_up = 2'd3;
    step();
    chk("spd_chg_cycle", 32'(bus.time_bcd), 32'h010000);
    step();
    chk("spd_chg_plus1", 32'(bus.time_bcd), 32'h010000);
    step();
    chk("spd_chg_plus2", 32'(bus.time_bcd), 32'h010001);
    step();
    push(24'h050505, 0, 0, 0);
    bus.load_bcd = 24'h050505;
    bus.load     = 1'b1;
    step();
    bus.load = 1'b0;
    bus.run  = 1'b0;
    chk("load_on_tick", 32'(bus.time_bcd), 32'h050505);

    repeat (4) step();
    chk("events_left", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
